// File: rtl/mux_stream_n.sv
// N-input stream multiplexer: a select token picks one source channel and the chosen
// word (or ERR_VAL for an out-of-range select) is queued in a 2-entry skid buffer.
module mux_stream_n #(
  parameter int          WIDTH   = 32,
  parameter int          NUM_IN  = 8,
  parameter int          SEL_W   = $clog2(NUM_IN),
  parameter logic [31:0] ERR_VAL = 32'd1234567890
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Handshake rule for every port pair: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready from this block.

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int               EW       = WIDTH + SEL_W + 1;
  localparam logic [WIDTH-1:0] ERR_WORD = WIDTH'(ERR_VAL);

  // Buffer entries are packed as {err, tag, data}; head_q is the word on the outputs.
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;

  logic [WIDTH-1:0] sel_word;
  logic             sel_in_valid;
  logic             oor;
  logic             full;
  logic             fire;
  logic             pop;
  logic [EW-1:0]    push_entry;

  always_comb begin
    sel_word     = '0;
    sel_in_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_word     = in_data[i*WIDTH +: WIDTH];
        sel_in_valid = in_valid[i];
      end
    end
  end

  // Widened compare so NUM_IN == 2**SEL_W still fits the constant.
  assign oor  = ({1'b0, sel} >= (SEL_W + 1)'(NUM_IN));
  assign full = (count_q == ST_FULL);
  // Tokens are never consumed while reset is held, so the source sees no stray ready.
  assign fire = !reset && sel_valid && !full && (oor || sel_in_valid);
  assign pop  = (count_q != ST_EMPTY) && out_ready;

  assign sel_ready  = fire;
  assign push_entry = oor ? {1'b1, sel, ERR_WORD} : {1'b0, sel, sel_word};

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = fire && !oor && (sel == SEL_W'(i));
    end
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      ST_EMPTY: begin
        if (fire) begin
          head_d  = push_entry;
          count_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (fire && !pop) begin
          tail_d  = push_entry;
          count_d = ST_FULL;
        end else if (fire && pop) begin
          head_d = push_entry;
        end else if (pop) begin
          count_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = ST_ONE;
        end
      end
      default: count_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_valid = (count_q != ST_EMPTY);
  assign {out_err, out_sel, out_data} = head_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed bench for mux_stream_n: an 8-channel instance for the main stream paths and
// a 5-channel instance for out-of-range select handling.
module tb_mux_stream_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-channel instance
  logic [2:0]   sel8;
  logic         sel_valid8, sel_ready8;
  logic [255:0] in_data8;
  logic [7:0]   in_valid8, in_ready8;
  logic [31:0]  out_data8;
  logic [2:0]   out_sel8;
  logic         out_err8, out_valid8, out_ready8;

  // 5-channel instance
  logic [2:0]   sel5;
  logic         sel_valid5, sel_ready5;
  logic [159:0] in_data5;
  logic [4:0]   in_valid5, in_ready5;
  logic [31:0]  out_data5;
  logic [2:0]   out_sel5;
  logic         out_err5, out_valid5, out_ready5;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];

  mux_stream_n #(.WIDTH(32), .NUM_IN(8)) u_dut8 (
    .clk(clk), .reset(reset), .sel(sel8), .sel_valid(sel_valid8), .sel_ready(sel_ready8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_sel(out_sel8), .out_err(out_err8),
    .out_valid(out_valid8), .out_ready(out_ready8)
  );

  mux_stream_n #(.WIDTH(32), .NUM_IN(5)) u_dut5 (
    .clk(clk), .reset(reset), .sel(sel5), .sel_valid(sel_valid5), .sel_ready(sel_ready5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_sel(out_sel5), .out_err(out_err5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel_valid8 = 1'b1; sel8 = 3'd0; out_ready8 = 1'b1;
    step();
    step();
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h exp 0", out_valid8); end
    checks++; if (out_data8 !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %0h exp 0", out_data8); end
    checks++; if ({out_err8, out_sel8} !== 4'h0) begin errors++; $display("FAIL reset_err_sel: got %0h exp 0", {out_err8, out_sel8}); end
    checks++; if (in_ready8 !== 8'h00) begin errors++; $display("FAIL reset_in_ready: got %0h exp 0", in_ready8); end
    checks++; if (sel_ready8 !== 1'b0) begin errors++; $display("FAIL reset_sel_ready: got %0h exp 0", sel_ready8); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready8 !== 8'h01) begin errors++; $display("FAIL post_reset_in_ready: got %0h exp 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %0h exp 0", out_valid8); end
    step();
    sel_valid8 = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL first_word_valid: got %0h exp 1", out_valid8); end
    checks++; if (out_data8 !== 32'hA000_0000) begin errors++; $display("FAIL first_word_data: got %0h exp a0000000", out_data8); end
    step();
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL first_word_drain: got %0h exp 0", out_valid8); end
  endtask

  task automatic test_sweep();
    int delivered;
    delivered = 0;
    out_ready8 = 1'b1; sel_valid8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel8 = 3'(i);
      #1;
      checks++; if (sel_ready8 !== 1'b1) begin errors++; $display("FAIL sweep_sel_ready[%0d]: got %0h exp 1", i, sel_ready8); end
      if (i > 0) begin
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL sweep_out_valid[%0d]: got %0h exp 1", i, out_valid8); end
      end
      if (out_valid8 === 1'b1 && exp_q.size() > 0) begin
        checks++; if ({out_err8, out_sel8, out_data8} !== exp_q[0]) begin errors++; $display("FAIL sweep_word: got %0h exp %0h", {out_err8, out_sel8, out_data8}, exp_q[0]); end
        void'(exp_q.pop_front());
        delivered++;
      end
      exp_q.push_back({1'b0, 3'(i), 32'hA000_0000 + 32'(i)});
      step();
    end
    sel_valid8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid8 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sweep_extra_word: got %0h exp none", out_data8); end
        else begin
          if ({out_err8, out_sel8, out_data8} !== exp_q[0]) begin errors++; $display("FAIL sweep_word: got %0h exp %0h", {out_err8, out_sel8, out_data8}, exp_q[0]); end
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      step();
    end
    checks++; if (delivered != 8) begin errors++; $display("FAIL sweep_count: got %0d exp 8", delivered); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready8 = 1'b0; sel_valid8 = 1'b1; sel8 = 3'd3;
    #1;
    checks++; if (sel_ready8 !== 1'b1) begin errors++; $display("FAIL bp_accept3: got %0h exp 1", sel_ready8); end
    step();
    sel8 = 3'd5;
    #1;
    checks++; if (sel_ready8 !== 1'b1) begin errors++; $display("FAIL bp_accept5: got %0h exp 1", sel_ready8); end
    step();
    sel8 = 3'd6;
    #1;
    checks++; if (sel_ready8 !== 1'b0) begin errors++; $display("FAIL bp_full_sel_ready: got %0h exp 0", sel_ready8); end
    checks++; if (in_ready8 !== 8'h00) begin errors++; $display("FAIL bp_full_in_ready: got %0h exp 0", in_ready8); end
    step();
    #1;
    checks++; if ({out_sel8, out_data8} !== {3'd3, 32'hA000_0003}) begin errors++; $display("FAIL bp_hold_head: got %0h exp 3a0000003", {out_sel8, out_data8}); end
    out_ready8 = 1'b1;
    #1;
    checks++; if (sel_ready8 !== 1'b0) begin errors++; $display("FAIL bp_no_comb_path: got %0h exp 0", sel_ready8); end
    step();
    #1;
    checks++; if (out_data8 !== 32'hA000_0005) begin errors++; $display("FAIL bp_second: got %0h exp a0000005", out_data8); end
    checks++; if (sel_ready8 !== 1'b1) begin errors++; $display("FAIL bp_accept6: got %0h exp 1", sel_ready8); end
    step();
    sel_valid8 = 1'b0;
    #1;
    checks++; if ({out_valid8, out_sel8, out_data8} !== {1'b1, 3'd6, 32'hA000_0006}) begin errors++; $display("FAIL bp_third: got %0h exp ea0000006", {out_valid8, out_sel8, out_data8}); end
    step();
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0h exp 0", out_valid8); end
  endtask

  task automatic test_out_of_range();
    out_ready5 = 1'b1; sel_valid5 = 1'b1; sel5 = 3'd6;
    #1;
    checks++; if (sel_ready5 !== 1'b1) begin errors++; $display("FAIL oor_sel_ready: got %0h exp 1", sel_ready5); end
    checks++; if (in_ready5 !== 5'b0) begin errors++; $display("FAIL oor_in_ready: got %0h exp 0", in_ready5); end
    step();
    sel5 = 3'd4;
    #1;
    checks++; if ({out_valid5, out_err5, out_sel5, out_data5} !== {1'b1, 1'b1, 3'd6, 32'd1234567890}) begin errors++; $display("FAIL oor_word: got %0h exp %0h", {out_valid5, out_err5, out_sel5, out_data5}, {1'b1, 1'b1, 3'd6, 32'd1234567890}); end
    checks++; if (in_ready5 !== 5'b10000) begin errors++; $display("FAIL last_ch_in_ready: got %0h exp 10", in_ready5); end
    step();
    sel5 = 3'd5;
    #1;
    checks++; if ({out_err5, out_sel5, out_data5} !== {1'b0, 3'd4, 32'hB000_0004}) begin errors++; $display("FAIL last_ch_word: got %0h exp 4b0000004", {out_err5, out_sel5, out_data5}); end
    checks++; if (in_ready5 !== 5'b0) begin errors++; $display("FAIL oor_edge_in_ready: got %0h exp 0", in_ready5); end
    step();
    sel_valid5 = 1'b0;
    #1;
    checks++; if ({out_err5, out_sel5, out_data5} !== {1'b1, 3'd5, 32'd1234567890}) begin errors++; $display("FAIL oor_edge_word: got %0h exp %0h", {out_err5, out_sel5, out_data5}, {1'b1, 3'd5, 32'd1234567890}); end
    step();
    #1;
    checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL oor_drained: got %0h exp 0", out_valid5); end
  endtask

  task automatic test_stall_source();
    out_ready8 = 1'b1; sel_valid8 = 1'b1; sel8 = 3'd2; in_valid8[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({sel_ready8, in_ready8, out_valid8} !== 10'h0) begin errors++; $display("FAIL stall_cycle[%0d]: got %0h exp 0", c, {sel_ready8, in_ready8, out_valid8}); end
      step();
    end
    in_valid8[2] = 1'b1;
    #1;
    checks++; if (in_ready8 !== 8'h04) begin errors++; $display("FAIL stall_release_in_ready: got %0h exp 4", in_ready8); end
    step();
    sel_valid8 = 1'b0;
    #1;
    checks++; if ({out_valid8, out_data8} !== {1'b1, 32'hA000_0002}) begin errors++; $display("FAIL stall_word: got %0h exp 1a0000002", {out_valid8, out_data8}); end
    step();
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL stall_single_push: got %0h exp 0", out_valid8); end
  endtask

  task automatic test_reset_mid();
    out_ready8 = 1'b0; sel_valid8 = 1'b1; sel8 = 3'd1;
    step();
    sel8 = 3'd4;
    step();
    #1;
    checks++; if ({out_valid8, sel_ready8} !== 2'b10) begin errors++; $display("FAIL mid_full: got %0h exp 2", {out_valid8, sel_ready8}); end
    reset = 1'b1; sel_valid8 = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checks++; if ({out_valid8, out_data8} !== 33'h0) begin errors++; $display("FAIL mid_reset_empty: got %0h exp 0", {out_valid8, out_data8}); end
    out_ready8 = 1'b1;
    step();
    #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %0h exp 0", out_valid8); end
  endtask

  initial begin
    reset = 1'b1;
    sel8 = '0; sel_valid8 = 1'b0; out_ready8 = 1'b0; in_valid8 = '1;
    sel5 = '0; sel_valid5 = 1'b0; out_ready5 = 1'b0; in_valid5 = '1;
    for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    test_reset();
    test_sweep();
    test_backpressure();
    test_out_of_range();
    test_stall_source();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
